// File: rtl/seq_match_logger.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_logger
// Description : Timestamps each cycle on which the sequence detector reports
//               a match. It uses a free-running cycle counter and buffers the
//               timestamps in a show-ahead circular FIFO. The FIFO is read
//               over a valid/ready handshake. The block also keeps a
//               saturating match count and a sticky flag for lost events.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       in_match,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam int                 c_lvl_w      = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full_level = c_lvl_w'(DEPTH);
    localparam logic [CNT_W-1:0]   c_cnt_max    = {CNT_W{1'b1}};

    // The pointers wrap by plain binary overflow. This only addresses the
    // buffer correctly when DEPTH is a power of two.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("seq_match_logger: DEPTH must be a power of two, >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TS_W-1:0]    r_ts;
    logic [TS_W-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_match;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_cnt_sat;

    // Decode the push/pop/drop qualifiers. A clear suppresses all of them.
    // A pop on a full FIFO frees the slot that a same-edge push fills.
    always_comb begin
        w_empty   = (r_level == '0);
        w_full    = (r_level == c_full_level);
        w_match   = in_match & ~clr;
        w_pop     = ~w_empty & rd_ready & ~clr;
        w_push    = w_match & (~w_full | w_pop);
        w_drop    = w_match & w_full & ~w_pop;
        w_cnt_sat = (r_count == c_cnt_max);
    end

    // ------------------------------------------------------------------------
    // Free-running timestamp. A push captures the value before the increment.
    // ------------------------------------------------------------------------
    // Timestamp counter that wraps naturally. It restarts on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else if (clr) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Circular buffer
    // ------------------------------------------------------------------------
    // Storage array. Its contents need no reset because the level gates them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
    end

    // Read pointer advances on every pop. The next entry shows ahead at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    // Occupancy counter. A simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else if (clr) begin
            r_level <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
    // Count every match, whether or not it is stored. Saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_match && !w_cnt_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Sticky flag. It is set the first time a match finds no free slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Outputs decode from registers only. The head reads as zero when empty.
    always_comb begin
        rd_valid    = ~w_empty;
        rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
        fifo_level  = r_level;
        match_count = r_count;
        overflow    = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_match_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_match_logger
// Description : Directed testbench for seq_match_logger. Expected timestamps
//               are queued when a match is issued. A negedge monitor checks
//               every popped head entry against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_match_logger;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_match;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  fifo_level;
    logic [7:0]  match_count;
    logic        overflow;

    int          errors;
    int          checks;
    logic [15:0] sb [$];
    logic [15:0] tb_ts;

    seq_match_logger #(
        .TS_W  (16),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .in_match    (in_match),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fifo_level  (fifo_level),
        .match_count (match_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: the timestamp the next rising edge will capture
    always @(posedge clk or negedge reset) begin
        if (!reset)   tb_ts <= 16'h0000;
        else if (clr) tb_ts <= 16'h0000;
        else          tb_ts <= tb_ts + 16'h0001;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a pop happens on the next rising edge
    always @(negedge clk) begin
        if (reset === 1'b1 && clr === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h, expected no entry (t=%0t)", rd_data, $time);
            end else begin
                check("pop_data", {16'h0, rd_data}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Advance one clock and settle 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [15:0] t);
        int n;
        n = 0;
        while (tb_ts !== t && n < 70000) begin
            step();
            n++;
        end
        if (tb_ts !== t) begin
            checks++;
            errors++;
            $display("FAIL wait_ts_timeout: got %0h, expected %0h", tb_ts, t);
        end
    endtask

    // Issue one match on the edge that captures timestamp t
    task automatic match_at(input logic [15:0] t, input bit accept);
        wait_ts(t);
        in_match = 1'b1;
        if (accept) sb.push_back(t);
        step();
        in_match = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sb.delete();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        clr      = 1'b0;
        in_match = 1'b0;
        rd_ready = 1'b0;

        // Reset values
        #12;
        check("rst_valid",    rd_valid,    0);
        check("rst_data",     rd_data,     0);
        check("rst_level",    fifo_level,  0);
        check("rst_count",    match_count, 0);
        check("rst_overflow", overflow,    0);
        @(negedge clk);
        reset = 1'b1;

        // Test 1: single match at ts=5, one-cycle latency
        match_at(16'd5, 1'b1);
        check("t1_valid", rd_valid,    1);
        check("t1_data",  rd_data,     16'd5);
        check("t1_level", fifo_level,  1);
        check("t1_count", match_count, 1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("t1_empty", fifo_level, 0);

        // Test 2: overflow when full without a pop
        do_clr();
        check("t2_clr_count", match_count, 0);
        match_at(16'd3, 1'b1);
        match_at(16'd4, 1'b1);
        match_at(16'd5, 1'b1);
        match_at(16'd6, 1'b1);
        match_at(16'd9, 1'b0);
        check("t2_level",    fifo_level,  4);
        check("t2_overflow", overflow,    1);
        check("t2_count",    match_count, 5);
        rd_ready = 1'b1;
        repeat (4) step();
        check("t2_drained_valid", rd_valid, 0);
        rd_ready = 1'b0;
        check("t2_sticky", overflow, 1);

        // Test 3: full with a push and a pop on the same edge
        do_clr();
        check("t3_clr_overflow", overflow, 0);
        match_at(16'd10, 1'b1);
        match_at(16'd11, 1'b1);
        match_at(16'd12, 1'b1);
        match_at(16'd13, 1'b1);
        wait_ts(16'd20);
        in_match = 1'b1;
        rd_ready = 1'b1;
        sb.push_back(16'd20);
        step();
        in_match = 1'b0;
        rd_ready = 1'b0;
        check("t3_overflow", overflow,   0);
        check("t3_level",    fifo_level, 4);
        check("t3_head",     rd_data,    16'd11);
        rd_ready = 1'b1;
        repeat (4) step();
        rd_ready = 1'b0;
        check("t3_empty", rd_valid, 0);

        // Test 4: counter saturation under continuous reads, then ts wrap
        do_clr();
        rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_match = 1'b1;
            sb.push_back(tb_ts);
            step();
        end
        in_match = 1'b0;
        step();
        check("t4_sat", match_count, 255);
        match_at(tb_ts, 1'b1);
        step();
        check("t4_sat_hold", match_count, 255);
        check("t4_no_overflow", overflow, 0);
        match_at(16'hFFFF, 1'b1);
        match_at(16'h0000, 1'b1);
        step();
        rd_ready = 1'b0;
        check("t4_drained", fifo_level, 0);

        // Test 5: clear beats a simultaneous match
        do_clr();
        match_at(16'd1, 1'b1);
        match_at(16'd2, 1'b1);
        match_at(16'd3, 1'b1);
        match_at(16'd4, 1'b1);
        match_at(16'd5, 1'b0);
        rd_ready = 1'b1;
        repeat (2) step();
        rd_ready = 1'b0;
        check("t5_pre_level",    fifo_level, 2);
        check("t5_pre_overflow", overflow,   1);
        clr      = 1'b1;
        in_match = 1'b1;
        step();
        clr      = 1'b0;
        in_match = 1'b0;
        sb.delete();
        check("t5_level",    fifo_level,  0);
        check("t5_valid",    rd_valid,    0);
        check("t5_count",    match_count, 0);
        check("t5_overflow", overflow,    0);
        repeat (3) step();
        in_match = 1'b1;
        sb.push_back(16'd3);
        step();
        in_match = 1'b0;
        check("t5_ts_restart", rd_data, 16'd3);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;

        // Test 6: asynchronous reset mid-operation
        do_clr();
        match_at(16'd0, 1'b0);
        match_at(16'd1, 1'b0);
        match_at(16'd2, 1'b0);
        check("t6_pre_level", fifo_level, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid",    rd_valid,    0);
        check("t6_data",     rd_data,     0);
        check("t6_level",    fifo_level,  0);
        check("t6_count",    match_count, 0);
        check("t6_overflow", overflow,    0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) step();
        in_match = 1'b1;
        sb.push_back(16'd2);
        step();
        in_match = 1'b0;
        check("t6_after_data", rd_data, 16'd2);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        step();

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
